// File: rtl/tlt_tl_adapter_pkg.sv
// Shared TileLink-UL encodings and helpers for the test-driver to TL-UL adapter.
package tlt_tl_adapter_pkg;

  localparam logic [2:0] TL_A_PUT_FULL_DATA   = 3'd0;
  localparam logic [2:0] TL_A_GET             = 3'd4;
  localparam logic [2:0] TL_D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_D_ACCESS_ACK_DATA = 3'd1;

  typedef struct packed {
    logic pending;
    logic done;
    logic is_write;
  } rob_ctl_t;

  // TL a_size is log2 of the transfer size in bytes.
  function automatic logic [2:0] tl_size(input int data_bits);
    return 3'($clog2(data_bits / 8));
  endfunction

endpackage

// File: rtl/tlt_tl_adapter_if.sv
// Bundles the driver request/response stream, TL A/D channels and error flags.
interface tlt_tl_adapter_if #(
  parameter int ADDR_BITS = 64,
  parameter int DATA_BITS = 32,
  parameter int INFLIGHT  = 4
);
  localparam int SRC_BITS = $clog2(INFLIGHT);

  logic                   tlt_req_valid;
  logic                   tlt_req_ready;
  logic [ADDR_BITS-1:0]   tlt_req_bits_addr;
  logic [DATA_BITS-1:0]   tlt_req_bits_data;
  logic                   tlt_req_bits_is_write;
  logic                   tlt_resp_valid;
  logic [DATA_BITS-1:0]   tlt_resp_bits_data;

  logic                   a_valid;
  logic                   a_ready;
  logic [2:0]             a_opcode;
  logic [2:0]             a_param;
  logic [2:0]             a_size;
  logic [SRC_BITS-1:0]    a_source;
  logic [ADDR_BITS-1:0]   a_address;
  logic [DATA_BITS/8-1:0] a_mask;
  logic [DATA_BITS-1:0]   a_data;

  logic                   d_valid;
  logic                   d_ready;
  logic [2:0]             d_opcode;
  logic [SRC_BITS-1:0]    d_source;
  logic [DATA_BITS-1:0]   d_data;
  logic                   d_denied;
  logic                   d_corrupt;

  logic                   err_denied;
  logic                   err_unexpected;

  modport master (
    input  tlt_req_valid, tlt_req_bits_addr, tlt_req_bits_data, tlt_req_bits_is_write,
    output tlt_req_ready, tlt_resp_valid, tlt_resp_bits_data,
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    input  a_ready,
    input  d_valid, d_opcode, d_source, d_data, d_denied, d_corrupt,
    output d_ready,
    output err_denied, err_unexpected
  );

  modport slave (
    output tlt_req_valid, tlt_req_bits_addr, tlt_req_bits_data, tlt_req_bits_is_write,
    input  tlt_req_ready, tlt_resp_valid, tlt_resp_bits_data,
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    output a_ready,
    output d_valid, d_opcode, d_source, d_data, d_denied, d_corrupt,
    input  d_ready,
    input  err_denied, err_unexpected
  );

endinterface

// File: rtl/tlt_rob.sv
// Reorder buffer: allocates in order at tail, completes by source index, retires in order at head.
module tlt_rob
  import tlt_tl_adapter_pkg::*;
#(
  parameter int DATA_BITS = 32,
  parameter int INFLIGHT  = 4,
  localparam int IDX_W    = $clog2(INFLIGHT)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 alloc_en,
  input  logic                 alloc_is_write,
  output logic [IDX_W-1:0]     tail,
  output logic                 slot_free,
  input  logic                 cmpl_en,
  input  logic [IDX_W-1:0]     cmpl_idx,
  input  logic [DATA_BITS-1:0] cmpl_data,
  output logic                 cmpl_ok,
  output logic                 resp_valid,
  output logic [DATA_BITS-1:0] resp_data
);

  localparam logic [IDX_W:0] CAPACITY = (IDX_W+1)'(INFLIGHT);

  rob_ctl_t             ctl  [INFLIGHT];
  logic [DATA_BITS-1:0] data [INFLIGHT];
  logic [IDX_W-1:0]     head;
  logic [IDX_W-1:0]     tail_q;
  logic [IDX_W:0]       count;
  logic                 retire;

  assign tail      = tail_q;
  assign slot_free = (count < CAPACITY);
  assign retire    = ctl[head].pending && ctl[head].done;
  // A beat for the slot being allocated this cycle is not yet pending and so is rejected.
  assign cmpl_ok   = ctl[cmpl_idx].pending && !ctl[cmpl_idx].done;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < INFLIGHT; i++) begin
        ctl[i]  <= '0;
        data[i] <= '0;
      end
      head       <= '0;
      tail_q     <= '0;
      count      <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
    end else begin
      for (int i = 0; i < INFLIGHT; i++) begin
        if (retire && head == IDX_W'(i)) begin
          ctl[i]  <= '0;
          data[i] <= '0;
        end
        if (alloc_en && tail_q == IDX_W'(i)) begin
          ctl[i] <= '{pending: 1'b1, done: 1'b0, is_write: alloc_is_write};
        end
        if (cmpl_en && cmpl_ok && cmpl_idx == IDX_W'(i)) begin
          ctl[i].done <= 1'b1;
          data[i]     <= ctl[i].is_write ? '0 : cmpl_data;
        end
      end

      if (alloc_en) tail_q <= tail_q + 1'b1;
      if (retire)   head   <= head + 1'b1;

      case ({alloc_en, retire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      resp_valid <= retire;
      resp_data  <= retire ? data[head] : '0;
    end
  end

endmodule

// File: rtl/tlt_tl_adapter.sv
// Converts the driver's request stream into TL-UL Get/PutFullData and returns in-order responses.
module tlt_tl_adapter
  import tlt_tl_adapter_pkg::*;
#(
  parameter int ADDR_BITS = 64,
  parameter int DATA_BITS = 32,
  parameter int INFLIGHT  = 4,
  localparam int SRC_BITS = $clog2(INFLIGHT)
) (
  input logic         clock,
  input logic         reset,
  tlt_tl_adapter_if.master bus
);

  logic                 slot_free;
  logic                 accept;
  logic                 cmpl_ok;
  logic [SRC_BITS-1:0]  tail;
  logic [DATA_BITS-1:0] cmpl_data;
  logic                 resp_valid;
  logic [DATA_BITS-1:0] resp_data;
  logic                 err_denied_q;
  logic                 err_unexpected_q;

  // Issue is a pure pass-through gated only by ROB occupancy.
  assign bus.a_valid       = bus.tlt_req_valid && slot_free;
  assign bus.tlt_req_ready = bus.a_ready && slot_free;
  assign accept            = bus.tlt_req_valid && bus.tlt_req_ready;

  assign bus.a_opcode  = bus.tlt_req_bits_is_write ? TL_A_PUT_FULL_DATA : TL_A_GET;
  assign bus.a_param   = 3'd0;
  assign bus.a_size    = tl_size(DATA_BITS);
  assign bus.a_source  = tail;
  assign bus.a_address = bus.tlt_req_bits_addr;
  assign bus.a_mask    = '1;
  assign bus.a_data    = bus.tlt_req_bits_data;

  // Every pending source already owns a ROB slot, so D never needs back-pressure.
  assign bus.d_ready = 1'b1;
  // A dataless ack carries no read data; the ROB zeroes writes on its own.
  assign cmpl_data   = (bus.d_opcode == TL_D_ACCESS_ACK_DATA) ? bus.d_data : '0;

  tlt_rob #(
    .DATA_BITS (DATA_BITS),
    .INFLIGHT  (INFLIGHT)
  ) u_rob (
    .clock          (clock),
    .reset          (reset),
    .alloc_en       (accept),
    .alloc_is_write (bus.tlt_req_bits_is_write),
    .tail           (tail),
    .slot_free      (slot_free),
    .cmpl_en        (bus.d_valid),
    .cmpl_idx       (bus.d_source),
    .cmpl_data      (cmpl_data),
    .cmpl_ok        (cmpl_ok),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data)
  );

  assign bus.tlt_resp_valid     = resp_valid;
  assign bus.tlt_resp_bits_data = resp_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_denied_q     <= 1'b0;
      err_unexpected_q <= 1'b0;
    end else if (bus.d_valid) begin
      if (cmpl_ok) err_denied_q     <= err_denied_q | bus.d_denied | bus.d_corrupt;
      else         err_unexpected_q <= 1'b1;
    end
  end

  assign bus.err_denied     = err_denied_q;
  assign bus.err_unexpected = err_unexpected_q;

endmodule

// File: tb/tb_tlt_tl_adapter.sv
// Directed bench for tlt_tl_adapter: vector table for single transactions plus multi-cycle sequences.
module tb_tlt_tl_adapter;
  import tlt_tl_adapter_pkg::*;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  tlt_tl_adapter_if #(.ADDR_BITS(64), .DATA_BITS(32), .INFLIGHT(4)) bus ();

  tlt_tl_adapter #(.ADDR_BITS(64), .DATA_BITS(32), .INFLIGHT(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        is_write;
    logic [63:0] addr;
    logic [31:0] wdata;
    logic [2:0]  d_op;
    logic [31:0] d_data;
    logic [2:0]  exp_aop;
    logic [31:0] exp_resp;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.tlt_req_valid         = 1'b0;
    bus.tlt_req_bits_addr     = '0;
    bus.tlt_req_bits_data     = '0;
    bus.tlt_req_bits_is_write = 1'b0;
    bus.a_ready               = 1'b1;
    bus.d_valid               = 1'b0;
    bus.d_opcode              = 3'd0;
    bus.d_source              = '0;
    bus.d_data                = '0;
    bus.d_denied              = 1'b0;
    bus.d_corrupt             = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic drive_d(input logic [1:0] src, input logic [2:0] op, input logic [31:0] dat,
                         input logic denied);
    bus.d_valid  = 1'b1;
    bus.d_source = src;
    bus.d_opcode = op;
    bus.d_data   = dat;
    bus.d_denied = denied;
  endtask

  task automatic clear_d();
    bus.d_valid  = 1'b0;
    bus.d_denied = 1'b0;
    bus.d_data   = '0;
  endtask

  task automatic issue_read(input logic [63:0] addr);
    bus.tlt_req_valid         = 1'b1;
    bus.tlt_req_bits_is_write = 1'b0;
    bus.tlt_req_bits_addr     = addr;
  endtask

  initial begin
    logic [1:0] exp_src;
    checks = 0;
    errors = 0;

    vecs[0] = '{1'b0, 64'h1000, 32'h0, TL_D_ACCESS_ACK_DATA, 32'hDEADBEEF, 3'd4, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 64'h2000, 32'h12345678, TL_D_ACCESS_ACK, 32'h0, 3'd0, 32'h0};
    vecs[2] = '{1'b1, 64'h3004, 32'hA5A5A5A5, TL_D_ACCESS_ACK_DATA, 32'hFFFF0000, 3'd0, 32'h0};
    vecs[3] = '{1'b0, 64'h4008, 32'h0, TL_D_ACCESS_ACK, 32'h00000099, 3'd4, 32'h0};
    vecs[4] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0, TL_D_ACCESS_ACK_DATA, 32'h00000001, 3'd4,
                32'h00000001};

    // Reset state, observed while reset is still asserted.
    idle_inputs();
    reset = 1'b1;
    tick();
    chk("rst_resp_valid", 64'(bus.tlt_resp_valid), 64'd0);
    chk("rst_resp_data", 64'(bus.tlt_resp_bits_data), 64'd0);
    chk("rst_err_denied", 64'(bus.err_denied), 64'd0);
    chk("rst_err_unexp", 64'(bus.err_unexpected), 64'd0);
    chk("rst_d_ready", 64'(bus.d_ready), 64'd1);
    chk("rst_a_valid", 64'(bus.a_valid), 64'd0);
    chk("rst_req_ready", 64'(bus.tlt_req_ready), 64'd1);
    reset = 1'b0;
    tick();

    // Single transactions from the vector table.
    exp_src = 2'd0;
    for (int i = 0; i < 5; i++) begin
      bus.tlt_req_valid         = 1'b1;
      bus.tlt_req_bits_is_write = vecs[i].is_write;
      bus.tlt_req_bits_addr     = vecs[i].addr;
      bus.tlt_req_bits_data     = vecs[i].wdata;
      #1;
      chk($sformatf("v%0d_a_valid", i), 64'(bus.a_valid), 64'd1);
      chk($sformatf("v%0d_req_ready", i), 64'(bus.tlt_req_ready), 64'd1);
      chk($sformatf("v%0d_a_opcode", i), 64'(bus.a_opcode), 64'(vecs[i].exp_aop));
      chk($sformatf("v%0d_a_source", i), 64'(bus.a_source), 64'(exp_src));
      chk($sformatf("v%0d_a_size", i), 64'(bus.a_size), 64'd2);
      chk($sformatf("v%0d_a_mask", i), 64'(bus.a_mask), 64'hF);
      chk($sformatf("v%0d_a_param", i), 64'(bus.a_param), 64'd0);
      chk($sformatf("v%0d_a_address", i), bus.a_address, vecs[i].addr);
      if (vecs[i].is_write)
        chk($sformatf("v%0d_a_data", i), 64'(bus.a_data), 64'(vecs[i].wdata));
      tick();
      bus.tlt_req_valid = 1'b0;
      drive_d(exp_src, vecs[i].d_op, vecs[i].d_data, 1'b0);
      tick();
      clear_d();
      chk($sformatf("v%0d_resp_early", i), 64'(bus.tlt_resp_valid), 64'd0);
      tick();
      chk($sformatf("v%0d_resp_valid", i), 64'(bus.tlt_resp_valid), 64'd1);
      chk($sformatf("v%0d_resp_data", i), 64'(bus.tlt_resp_bits_data), 64'(vecs[i].exp_resp));
      tick();
      chk($sformatf("v%0d_resp_pulse", i), 64'(bus.tlt_resp_valid), 64'd0);
      exp_src = exp_src + 2'd1;
    end
    chk("tbl_err_denied", 64'(bus.err_denied), 64'd0);
    chk("tbl_err_unexp", 64'(bus.err_unexpected), 64'd0);

    // Reorder: three reads, D returns 2,0,1.
    do_reset();
    issue_read(64'h100);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("ro_src%0d", i), 64'(bus.a_source), 64'(i));
      tick();
    end
    bus.tlt_req_valid = 1'b0;
    drive_d(2'd2, TL_D_ACCESS_ACK_DATA, 32'hC, 1'b0);
    tick();
    drive_d(2'd0, TL_D_ACCESS_ACK_DATA, 32'hA, 1'b0);
    tick();
    chk("ro_wait0", 64'(bus.tlt_resp_valid), 64'd0);
    drive_d(2'd1, TL_D_ACCESS_ACK_DATA, 32'hB, 1'b0);
    tick();
    clear_d();
    chk("ro_r0_valid", 64'(bus.tlt_resp_valid), 64'd1);
    chk("ro_r0_data", 64'(bus.tlt_resp_bits_data), 64'hA);
    tick();
    chk("ro_r1_valid", 64'(bus.tlt_resp_valid), 64'd1);
    chk("ro_r1_data", 64'(bus.tlt_resp_bits_data), 64'hB);
    tick();
    chk("ro_r2_valid", 64'(bus.tlt_resp_valid), 64'd1);
    chk("ro_r2_data", 64'(bus.tlt_resp_bits_data), 64'hC);
    tick();
    chk("ro_end", 64'(bus.tlt_resp_valid), 64'd0);

    // Full: four reads outstanding block the fifth even with a_ready high.
    do_reset();
    issue_read(64'h200);
    for (int i = 0; i < 4; i++) tick();
    #1;
    chk("full_req_ready", 64'(bus.tlt_req_ready), 64'd0);
    chk("full_a_valid", 64'(bus.a_valid), 64'd0);
    tick();
    chk("full_hold", 64'(bus.tlt_req_ready), 64'd0);
    drive_d(2'd0, TL_D_ACCESS_ACK_DATA, 32'h11, 1'b0);
    tick();
    clear_d();
    chk("full_before_retire", 64'(bus.tlt_req_ready), 64'd0);
    tick();
    chk("full_retire_valid", 64'(bus.tlt_resp_valid), 64'd1);
    chk("full_retire_data", 64'(bus.tlt_resp_bits_data), 64'h11);
    chk("full_ready_back", 64'(bus.tlt_req_ready), 64'd1);
    chk("full_a_valid_back", 64'(bus.a_valid), 64'd1);
    chk("full_src_wrap", 64'(bus.a_source), 64'd0);
    tick();
    bus.tlt_req_valid = 1'b0;
    #1;
    chk("full_again", 64'(bus.tlt_req_ready), 64'd0);

    // Errors: unexpected source, then a denied read that still responds.
    do_reset();
    drive_d(2'd3, TL_D_ACCESS_ACK_DATA, 32'h33, 1'b0);
    tick();
    clear_d();
    chk("err_unexp_set", 64'(bus.err_unexpected), 64'd1);
    chk("err_den_clear", 64'(bus.err_denied), 64'd0);
    chk("err_no_resp0", 64'(bus.tlt_resp_valid), 64'd0);
    tick();
    chk("err_no_resp1", 64'(bus.tlt_resp_valid), 64'd0);
    issue_read(64'h300);
    tick();
    bus.tlt_req_valid = 1'b0;
    drive_d(2'd0, TL_D_ACCESS_ACK_DATA, 32'h55, 1'b1);
    tick();
    clear_d();
    chk("err_den_set", 64'(bus.err_denied), 64'd1);
    tick();
    chk("err_den_resp", 64'(bus.tlt_resp_valid), 64'd1);
    chk("err_den_data", 64'(bus.tlt_resp_bits_data), 64'h55);
    chk("err_unexp_sticky", 64'(bus.err_unexpected), 64'd1);
    // Second beat for a source that has already retired is unexpected, not a new completion.
    drive_d(2'd0, TL_D_ACCESS_ACK_DATA, 32'h66, 1'b0);
    tick();
    clear_d();
    tick();
    chk("err_dup_no_resp", 64'(bus.tlt_resp_valid), 64'd0);

    // Corrupt on a pending read also sets err_denied.
    do_reset();
    issue_read(64'h380);
    tick();
    bus.tlt_req_valid = 1'b0;
    bus.d_corrupt = 1'b1;
    drive_d(2'd0, TL_D_ACCESS_ACK_DATA, 32'h77, 1'b0);
    tick();
    clear_d();
    bus.d_corrupt = 1'b0;
    chk("corrupt_denied", 64'(bus.err_denied), 64'd1);
    chk("corrupt_unexp", 64'(bus.err_unexpected), 64'd0);

    // Reset with two reads pending drops all state asynchronously.
    do_reset();
    issue_read(64'h400);
    tick();
    tick();
    bus.tlt_req_valid = 1'b0;
    drive_d(2'd0, TL_D_ACCESS_ACK_DATA, 32'h44, 1'b1);
    tick();
    clear_d();
    reset = 1'b1;
    #1;
    chk("mid_rst_resp", 64'(bus.tlt_resp_valid), 64'd0);
    chk("mid_rst_data", 64'(bus.tlt_resp_bits_data), 64'd0);
    chk("mid_rst_err_den", 64'(bus.err_denied), 64'd0);
    chk("mid_rst_src", 64'(bus.a_source), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    drive_d(2'd0, TL_D_ACCESS_ACK_DATA, 32'h88, 1'b0);
    tick();
    clear_d();
    chk("late_unexp", 64'(bus.err_unexpected), 64'd1);
    chk("late_no_resp0", 64'(bus.tlt_resp_valid), 64'd0);
    tick();
    chk("late_no_resp1", 64'(bus.tlt_resp_valid), 64'd0);
    issue_read(64'h500);
    #1;
    chk("post_rst_a_valid", 64'(bus.a_valid), 64'd1);
    chk("post_rst_src", 64'(bus.a_source), 64'd0);
    tick();
    bus.tlt_req_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
